// File: rtl/rmt_walk_ctrl_pkg.sv
// Shared definitions for the rename map table write-port controller:
// walker state encoding and the number of SRAM write ports.
package rmt_walk_ctrl_pkg;

    localparam int NUM_WR_PORTS = 4;

    typedef enum logic [1:0] {
        INIT    = 2'd0,
        IDLE    = 2'd1,
        RECOVER = 2'd2
    } walk_state_e;

endpackage

// File: rtl/rmt_onehot_dec.sv
// Index-to-one-hot write address decoder with enable. A disabled port drives
// an all-zero vector so the SRAM sees no wordline for it.
module rmt_onehot_dec #(
    parameter int INDEX = 6,
    parameter int DEPTH = 64
) (
    input  logic             en,
    input  logic [INDEX-1:0] idx,
    output logic [DEPTH-1:0] onehot
);

    // Compare against every row so indices beyond DEPTH simply select nothing
    always_comb begin
        onehot = {DEPTH{1'b0}};
        for (int j = 0; j < DEPTH; j++) begin
            onehot[j] = en && (idx == INDEX'(j));
        end
    end

endmodule

// File: rtl/rmt_walk_ctrl.sv
// Owns the four SRAM write ports of the rename map table: identity init after
// reset, AMT copy on recovery, and zero-latency rename passthrough when idle.
module rmt_walk_ctrl
    import rmt_walk_ctrl_pkg::*;
#(
    parameter int SRAM_DEPTH = 64,
    parameter int SRAM_INDEX = 6,
    parameter int SRAM_WIDTH = 8
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 recover_i,
    input  logic [NUM_WR_PORTS-1:0]              rn_we_i,
    input  logic [NUM_WR_PORTS*SRAM_INDEX-1:0]   rn_addr_i,
    input  logic [NUM_WR_PORTS*SRAM_WIDTH-1:0]   rn_data_i,
    output logic [NUM_WR_PORTS*SRAM_INDEX-1:0]   amt_addr_o,
    input  logic [NUM_WR_PORTS*SRAM_WIDTH-1:0]   amt_data_i,
    output logic [NUM_WR_PORTS*SRAM_DEPTH-1:0]   decoded_addrwr_o,
    output logic [NUM_WR_PORTS*SRAM_WIDTH-1:0]   datawr_o,
    output logic [NUM_WR_PORTS-1:0]              we_o,
    output logic                                 stall_o,
    output logic                                 done_o
);

    localparam logic [SRAM_INDEX-1:0] LAST_PTR   = SRAM_INDEX'(SRAM_DEPTH - NUM_WR_PORTS);
    localparam logic [SRAM_INDEX-1:0] GROUP_STEP = SRAM_INDEX'(NUM_WR_PORTS);
    localparam logic [SRAM_INDEX-1:0] PTR_ZERO   = {SRAM_INDEX{1'b0}};

    walk_state_e                                  state_r;
    walk_state_e                                  state_s;
    logic [SRAM_INDEX-1:0]                        ptr_r;
    logic [SRAM_INDEX-1:0]                        ptr_s;
    logic                                         done_r;
    logic                                         done_s;
    logic                                         walking_s;
    logic [NUM_WR_PORTS-1:0][SRAM_INDEX-1:0]      walk_idx_s;
    logic [NUM_WR_PORTS-1:0][SRAM_INDEX-1:0]      dec_idx_s;
    logic [NUM_WR_PORTS-1:0]                      dec_en_s;
    logic [NUM_WR_PORTS-1:0][SRAM_WIDTH-1:0]      data_s;

    // Walker state, group pointer and completion pulse registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= INIT;
            ptr_r   <= PTR_ZERO;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            ptr_r   <= ptr_s;
            done_r  <= done_s;
        end
    end

    // Next-state logic; a recovery request during RECOVER (even on the last
    // group) restarts the copy and suppresses done, while INIT ignores it
    always_comb begin
        state_s = state_r;
        ptr_s   = ptr_r;
        done_s  = 1'b0;
        case (state_r)
            INIT: begin
                if (ptr_r == LAST_PTR) begin
                    state_s = IDLE;
                    ptr_s   = PTR_ZERO;
                    done_s  = 1'b1;
                end else begin
                    ptr_s = ptr_r + GROUP_STEP;
                end
            end
            RECOVER: begin
                if (recover_i) begin
                    ptr_s = PTR_ZERO;
                end else if (ptr_r == LAST_PTR) begin
                    state_s = IDLE;
                    ptr_s   = PTR_ZERO;
                    done_s  = 1'b1;
                end else begin
                    ptr_s = ptr_r + GROUP_STEP;
                end
            end
            IDLE: begin
                if (recover_i) begin
                    state_s = RECOVER;
                    ptr_s   = PTR_ZERO;
                end else begin
                    state_s = IDLE;
                end
            end
            default: begin
                state_s = INIT;
                ptr_s   = PTR_ZERO;
            end
        endcase
    end

    // Write-port mux: walker group while walking, rename requests when idle
    always_comb begin
        walking_s = (state_r != IDLE);
        for (int k = 0; k < NUM_WR_PORTS; k++) begin
            walk_idx_s[k] = ptr_r + SRAM_INDEX'(k);
            if (walking_s) begin
                dec_idx_s[k] = walk_idx_s[k];
                dec_en_s[k]  = 1'b1;
            end else begin
                dec_idx_s[k] = rn_addr_i[k*SRAM_INDEX +: SRAM_INDEX];
                dec_en_s[k]  = rn_we_i[k];
            end
            case (state_r)
                INIT:    data_s[k] = SRAM_WIDTH'(walk_idx_s[k]);
                RECOVER: data_s[k] = amt_data_i[k*SRAM_WIDTH +: SRAM_WIDTH];
                default: data_s[k] = rn_data_i[k*SRAM_WIDTH +: SRAM_WIDTH];
            endcase
        end
    end

    for (genvar g = 0; g < NUM_WR_PORTS; g++) begin : g_dec
        rmt_onehot_dec #(
            .INDEX (SRAM_INDEX),
            .DEPTH (SRAM_DEPTH)
        ) u_dec (
            .en     (dec_en_s[g]),
            .idx    (dec_idx_s[g]),
            .onehot (decoded_addrwr_o[g*SRAM_DEPTH +: SRAM_DEPTH])
        );
    end

    assign amt_addr_o = walk_idx_s;
    assign datawr_o   = data_s;
    assign we_o       = dec_en_s;
    assign stall_o    = walking_s;
    assign done_o     = done_r;

endmodule

// File: tb/tb_rmt_walk_ctrl.sv
// Directed bench for rmt_walk_ctrl with a behavioural 64x8 SRAM (highest port
// wins) and an AMT that returns index XOR 0xFF.
module tb_rmt_walk_ctrl;

    localparam int D = 64;
    localparam int I = 6;
    localparam int W = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          recover_i;
    logic [3:0]    rn_we_i;
    logic [23:0]   rn_addr_i;
    logic [31:0]   rn_data_i;
    logic [23:0]   amt_addr_o;
    logic [31:0]   amt_data_i;
    logic [255:0]  decoded_addrwr_o;
    logic [31:0]   datawr_o;
    logic [3:0]    we_o;
    logic          stall_o;
    logic          done_o;

    logic [7:0]    mem [D];
    int            passed = 0;
    int            total  = 0;

    typedef struct {
        logic [3:0]       we;
        logic [3:0][5:0]  addr;
        logic [3:0][7:0]  data;
        logic [3:0]       exp_we;
        logic [3:0][5:0]  exp_pos;
        logic [5:0]       rd_addr;
        logic [7:0]       rd_val;
    } vec_t;

    vec_t tv [6];

    rmt_walk_ctrl #(.SRAM_DEPTH(D), .SRAM_INDEX(I), .SRAM_WIDTH(W)) dut (
        .clk              (clk),
        .reset            (reset),
        .recover_i        (recover_i),
        .rn_we_i          (rn_we_i),
        .rn_addr_i        (rn_addr_i),
        .rn_data_i        (rn_data_i),
        .amt_addr_o       (amt_addr_o),
        .amt_data_i       (amt_data_i),
        .decoded_addrwr_o (decoded_addrwr_o),
        .datawr_o         (datawr_o),
        .we_o             (we_o),
        .stall_o          (stall_o),
        .done_o           (done_o)
    );

    always #5 clk = ~clk;

    always_comb begin
        amt_data_i = 32'h0;
        for (int k = 0; k < 4; k++) begin
            amt_data_i[k*8 +: 8] = {2'b00, amt_addr_o[k*6 +: 6]} ^ 8'hFF;
        end
    end

    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (we_o[k]) begin
                for (int j = 0; j < D; j++) begin
                    if (decoded_addrwr_o[k*D + j]) mem[j] <= datawr_o[k*8 +: 8];
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [23:0] g_addr(input int b);
        logic [23:0] r;
        for (int k = 0; k < 4; k++) r[k*6 +: 6] = 6'(b + k);
        return r;
    endfunction

    function automatic logic [31:0] g_data(input int b, input bit inv);
        logic [31:0] r;
        for (int k = 0; k < 4; k++) r[k*8 +: 8] = 8'(b + k) ^ (inv ? 8'hFF : 8'h00);
        return r;
    endfunction

    function automatic logic [255:0] g_dec(input int b);
        logic [255:0] r;
        r = 256'h0;
        for (int k = 0; k < 4; k++) r[k*D + b + k] = 1'b1;
        return r;
    endfunction

    initial begin
        int          stall_cnt;
        int          done_cnt;
        int          first_done;
        logic [255:0] exp_dec;

        tv[0] = '{we:4'b0101, addr:{6'd7, 6'd10, 6'd5, 6'd10}, data:{8'h99, 8'h33, 8'h55, 8'h2A},
                  exp_we:4'b0101, exp_pos:{6'd0, 6'd10, 6'd0, 6'd10}, rd_addr:6'd10, rd_val:8'h33};
        tv[1] = '{we:4'b1111, addr:{6'd4, 6'd3, 6'd2, 6'd1}, data:{8'h44, 8'h33, 8'h22, 8'h11},
                  exp_we:4'b1111, exp_pos:{6'd4, 6'd3, 6'd2, 6'd1}, rd_addr:6'd4, rd_val:8'h44};
        tv[2] = '{we:4'b0000, addr:{6'd9, 6'd8, 6'd7, 6'd6}, data:{8'h01, 8'h02, 8'h03, 8'h04},
                  exp_we:4'b0000, exp_pos:{6'd0, 6'd0, 6'd0, 6'd0}, rd_addr:6'd20, rd_val:8'd20};
        tv[3] = '{we:4'b1000, addr:{6'd63, 6'd0, 6'd0, 6'd0}, data:{8'hAB, 8'h00, 8'h00, 8'h00},
                  exp_we:4'b1000, exp_pos:{6'd63, 6'd0, 6'd0, 6'd0}, rd_addr:6'd63, rd_val:8'hAB};
        tv[4] = '{we:4'b0010, addr:{6'd0, 6'd0, 6'd0, 6'd0}, data:{8'h00, 8'h00, 8'h5C, 8'h00},
                  exp_we:4'b0010, exp_pos:{6'd0, 6'd0, 6'd0, 6'd0}, rd_addr:6'd0, rd_val:8'h5C};
        tv[5] = '{we:4'b1010, addr:{6'd2, 6'd0, 6'd2, 6'd0}, data:{8'hD3, 8'h00, 8'hC1, 8'h00},
                  exp_we:4'b1010, exp_pos:{6'd2, 6'd0, 6'd2, 6'd0}, rd_addr:6'd2, rd_val:8'hD3};

        reset = 1'b1; recover_i = 1'b0;
        rn_we_i = 4'b0000; rn_addr_i = 24'h0; rn_data_i = 32'h0;
        step();
        reset = 1'b0;

        // Identity init after reset
        chk("rst_done", 256'(done_o), 256'(1'b0));
        for (int c = 0; c < 16; c++) begin
            chk("init_stall", 256'(stall_o), 256'(1'b1));
            chk("init_we", 256'(we_o), 256'(4'b1111));
            chk("init_dec", decoded_addrwr_o, g_dec(4 * c));
            chk("init_data", 256'(datawr_o), 256'(g_data(4 * c, 1'b0)));
            step();
        end
        chk("init_end_stall", 256'(stall_o), 256'(1'b0));
        chk("init_done", 256'(done_o), 256'(1'b1));
        step();
        chk("init_done_clr", 256'(done_o), 256'(1'b0));
        chk("init_mem37", 256'(mem[37]), 256'(8'd37));

        // Idle passthrough vectors
        for (int v = 0; v < 6; v++) begin
            rn_we_i = tv[v].we; rn_addr_i = tv[v].addr; rn_data_i = tv[v].data;
            #1;
            exp_dec = 256'h0;
            for (int k = 0; k < 4; k++) begin
                if (tv[v].exp_we[k]) exp_dec[k*D + int'(tv[v].exp_pos[k])] = 1'b1;
            end
            chk("idle_stall", 256'(stall_o), 256'(1'b0));
            chk("idle_we", 256'(we_o), 256'(tv[v].exp_we));
            chk("idle_dec", decoded_addrwr_o, exp_dec);
            chk("idle_data", 256'(datawr_o), 256'(tv[v].data));
            step();
            chk("idle_mem", 256'(mem[tv[v].rd_addr]), 256'(tv[v].rd_val));
        end

        // Recovery; rename write in the request cycle still goes through
        rn_we_i = 4'b0001; rn_addr_i = {6'd0, 6'd0, 6'd0, 6'd12}; rn_data_i = 32'h0000_0077;
        recover_i = 1'b1;
        #1;
        chk("rec_req_stall", 256'(stall_o), 256'(1'b0));
        chk("rec_req_we", 256'(we_o), 256'(4'b0001));
        chk("rec_req_dec", decoded_addrwr_o, 256'(1) << 12);
        step();
        recover_i = 1'b0;
        chk("rec_req_mem", 256'(mem[12]), 256'(8'h77));
        rn_we_i = 4'b1111; rn_addr_i = {4{6'd5}}; rn_data_i = {4{8'hEE}};
        for (int c = 0; c < 16; c++) begin
            chk("rec_stall", 256'(stall_o), 256'(1'b1));
            chk("rec_amt_addr", 256'(amt_addr_o), 256'(g_addr(4 * c)));
            chk("rec_we", 256'(we_o), 256'(4'b1111));
            chk("rec_dec", decoded_addrwr_o, g_dec(4 * c));
            chk("rec_data", 256'(datawr_o), 256'(g_data(4 * c, 1'b1)));
            step();
        end
        rn_we_i = 4'b0000;
        chk("rec_end_stall", 256'(stall_o), 256'(1'b0));
        chk("rec_done", 256'(done_o), 256'(1'b1));
        chk("rec_mem0", 256'(mem[0]), 256'(8'hFF));
        chk("rec_mem63", 256'(mem[63]), 256'(8'hC0));
        chk("rec_mem5", 256'(mem[5]), 256'(8'hFA));
        step();

        // Restart recovery at walk cycle 7
        recover_i = 1'b1;
        step();
        stall_cnt = 0; done_cnt = 0;
        for (int c = 0; c < 60; c++) begin
            if (stall_o) stall_cnt++;
            if (done_o) done_cnt++;
            if (c == 7) chk("restart_c7_addr", 256'(amt_addr_o), 256'(g_addr(28)));
            if (c == 8) chk("restart_c8_addr", 256'(amt_addr_o), 256'(g_addr(0)));
            recover_i = (c == 7);
            step();
        end
        chk("restart_stall_cnt", 256'(stall_cnt), 256'(24));
        chk("restart_done_cnt", 256'(done_cnt), 256'(1));

        // Reset at recover cycle 9, then recover ignored during INIT
        recover_i = 1'b1;
        step();
        recover_i = 1'b0;
        for (int c = 0; c < 9; c++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_rst_stall", 256'(stall_o), 256'(1'b1));
        chk("mid_rst_done", 256'(done_o), 256'(1'b0));
        chk("mid_rst_data", 256'(datawr_o), 256'(g_data(0, 1'b0)));
        first_done = -1; done_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            if (c == 5) chk("mid_rst_c5_data", 256'(datawr_o), 256'(g_data(20, 1'b0)));
            if (done_o) begin
                done_cnt++;
                if (first_done < 0) first_done = c;
            end
            recover_i = (c == 3);
            step();
        end
        recover_i = 1'b0;
        chk("mid_rst_first_done", 256'(first_done), 256'(16));
        chk("mid_rst_done_cnt", 256'(done_cnt), 256'(1));
        chk("mid_rst_mem37", 256'(mem[37]), 256'(8'd37));

        // Recovery request on the final group takes priority
        recover_i = 1'b1;
        step();
        recover_i = 1'b0;
        for (int c = 0; c < 15; c++) step();
        chk("last_grp_addr", 256'(amt_addr_o), 256'(g_addr(60)));
        recover_i = 1'b1;
        step();
        recover_i = 1'b0;
        chk("last_grp_stall", 256'(stall_o), 256'(1'b1));
        chk("last_grp_done", 256'(done_o), 256'(1'b0));
        chk("last_grp_addr0", 256'(amt_addr_o), 256'(g_addr(0)));
        stall_cnt = 0; done_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            if (stall_o) stall_cnt++;
            if (done_o) done_cnt++;
            step();
        end
        chk("last_grp_stall_cnt", 256'(stall_cnt), 256'(16));
        chk("last_grp_done_cnt", 256'(done_cnt), 256'(1));
        chk("last_grp_mem33", 256'(mem[33]), 256'(8'hDE));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
